// File: rtl/debug_bus_master.sv
// -----------------------------------------------------------------------------
// debug_bus_master
//
// Second initiator on the 68000-style system bus. An external debug/loader
// source offers single word or byte commands, and this block replays each one
// as one strobe/ack bus cycle into whichever responder decodes the address.
//
// Ports
//   clk30, reset      system clock, synchronous active-high reset
//   cmd_*             command handshake (valid/ready) with latched fields
//   rsp_*             one-cycle completion pulse plus held result fields
//   bus_req/bus_grant ownership handshake with the CPU-side arbiter
//   addr, as, uds, lds, write_strobe, data_out   bus cycle outputs
//   data_in, bus_ack, bus_err                    responder returns
//
// Every output is a register. The sequence of one bus cycle is
//   REQ -> SETUP (SETUP_CYCLES) -> STROBE (>=1) -> RELEASE (1) -> DONE (1)
// -----------------------------------------------------------------------------
module debug_bus_master #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int SETUP_CYCLES   = 1
) (
    input  logic        clk30,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [22:0] cmd_addr,
    input  logic        cmd_uds,
    input  logic        cmd_lds,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [22:0] addr,
    output logic        as,
    output logic        uds,
    output logic        lds,
    output logic        write_strobe,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    input  logic        bus_ack,
    input  logic        bus_err
);

    // STROBE counter only has to reach TIMEOUT_CYCLES-1.
    localparam int              TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE     = TO_W'(1);
    localparam logic [TO_W-1:0] TO_ZERO    = TO_W'(0);
    localparam logic [2:0]      SETUP_LOAD = 3'(SETUP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t          state_r;
    logic            write_r;
    logic [22:0]     addr_r;
    logic            uds_en_r;
    logic            lds_en_r;
    logic [15:0]     wdata_r;
    logic [15:0]     rdata_r;
    logic            err_r;
    logic            timeout_r;
    logic [2:0]      setup_cnt_r;
    logic [TO_W-1:0] to_cnt_r;

    // Command FSM: sequences one bus cycle and drives every output from a flop.
    always_ff @(posedge clk30) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
            bus_req      <= 1'b0;
            addr         <= 23'h000000;
            as           <= 1'b0;
            uds          <= 1'b0;
            lds          <= 1'b0;
            write_strobe <= 1'b0;
            data_out     <= 16'h0000;
            write_r      <= 1'b0;
            addr_r       <= 23'h000000;
            uds_en_r     <= 1'b0;
            lds_en_r     <= 1'b0;
            wdata_r      <= 16'h0000;
            rdata_r      <= 16'h0000;
            err_r        <= 1'b0;
            timeout_r    <= 1'b0;
            setup_cnt_r  <= 3'd0;
            to_cnt_r     <= TO_ZERO;
        end else begin
            // rsp_valid is a single-cycle pulse unless a branch re-asserts it.
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        write_r   <= cmd_write;
                        addr_r    <= cmd_addr;
                        uds_en_r  <= cmd_uds;
                        lds_en_r  <= cmd_lds;
                        wdata_r   <= cmd_wdata;
                        rdata_r   <= 16'h0000;
                        err_r     <= 1'b0;
                        timeout_r <= 1'b0;
                        cmd_ready <= 1'b0;
                        if (!cmd_uds && !cmd_lds) begin
                            // No lanes enabled: reject without touching the bus.
                            state_r     <= ST_DONE;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= 16'h0000;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                        end else begin
                            state_r <= ST_REQ;
                            bus_req <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (bus_grant) begin
                        state_r      <= ST_SETUP;
                        setup_cnt_r  <= SETUP_LOAD;
                        addr         <= addr_r;
                        as           <= 1'b1;
                        write_strobe <= write_r;
                        data_out     <= write_r ? wdata_r : 16'h0000;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end

                ST_SETUP: begin
                    if (!bus_grant) begin
                        // Arbiter withdrew the bus under us: abort as an error.
                        state_r      <= ST_RELEASE;
                        err_r        <= 1'b1;
                        timeout_r    <= 1'b0;
                        as           <= 1'b0;
                        uds          <= 1'b0;
                        lds          <= 1'b0;
                        write_strobe <= 1'b0;
                    end else if (setup_cnt_r <= 3'd1) begin
                        state_r  <= ST_STROBE;
                        uds      <= uds_en_r;
                        lds      <= lds_en_r;
                        to_cnt_r <= TO_ZERO;
                    end else begin
                        setup_cnt_r <= setup_cnt_r - 3'd1;
                    end
                end

                ST_STROBE: begin
                    if (!bus_grant) begin
                        state_r      <= ST_RELEASE;
                        err_r        <= 1'b1;
                        timeout_r    <= 1'b0;
                        as           <= 1'b0;
                        uds          <= 1'b0;
                        lds          <= 1'b0;
                        write_strobe <= 1'b0;
                    end else if (bus_err) begin
                        // Error wins over a simultaneous ack; read data is discarded.
                        state_r      <= ST_RELEASE;
                        err_r        <= 1'b1;
                        as           <= 1'b0;
                        uds          <= 1'b0;
                        lds          <= 1'b0;
                        write_strobe <= 1'b0;
                    end else if (bus_ack) begin
                        state_r      <= ST_RELEASE;
                        rdata_r      <= write_r ? 16'h0000 : data_in;
                        as           <= 1'b0;
                        uds          <= 1'b0;
                        lds          <= 1'b0;
                        write_strobe <= 1'b0;
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r      <= ST_RELEASE;
                        timeout_r    <= 1'b1;
                        as           <= 1'b0;
                        uds          <= 1'b0;
                        lds          <= 1'b0;
                        write_strobe <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end

                ST_RELEASE: begin
                    // One strobe-free cycle already elapsed; bus_req drops now.
                    state_r     <= ST_DONE;
                    bus_req     <= 1'b0;
                    addr        <= 23'h000000;
                    data_out    <= 16'h0000;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= rdata_r;
                    rsp_err     <= err_r;
                    rsp_timeout <= timeout_r;
                end

                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    // Unreachable encoding: park safely with the bus released.
                    state_r      <= ST_IDLE;
                    cmd_ready    <= 1'b1;
                    bus_req      <= 1'b0;
                    addr         <= 23'h000000;
                    as           <= 1'b0;
                    uds          <= 1'b0;
                    lds          <= 1'b0;
                    write_strobe <= 1'b0;
                    data_out     <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_bus_master.sv
// -----------------------------------------------------------------------------
// tb_debug_bus_master
//
// Directed and randomized bus transactions. A small responder/arbiter model
// answers the DUT, and each transaction's expected outcome (phase lengths,
// latency, returned data and status) is computed from the protocol rules.
// -----------------------------------------------------------------------------
module tb_debug_bus_master;

    localparam int TIMEOUT = 16;
    localparam int SETUP   = 2;

    logic        clk30 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [22:0] cmd_addr;
    logic        cmd_uds;
    logic        cmd_lds;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        bus_req;
    logic        bus_grant;
    logic [22:0] addr;
    logic        as;
    logic        uds;
    logic        lds;
    logic        write_strobe;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        bus_ack;
    logic        bus_err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] last_rdata = 16'h0000;
    logic        last_err   = 1'b0;
    logic        last_to    = 1'b0;

    debug_bus_master #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .SETUP_CYCLES   (SETUP)
    ) dut (
        .clk30        (clk30),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_uds      (cmd_uds),
        .cmd_lds      (cmd_lds),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_timeout  (rsp_timeout),
        .bus_req      (bus_req),
        .bus_grant    (bus_grant),
        .addr         (addr),
        .as           (as),
        .uds          (uds),
        .lds          (lds),
        .write_strobe (write_strobe),
        .data_out     (data_out),
        .data_in      (data_in),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk30 = ~clk30;

    // Hard stop in case something upstream never returns.
    initial begin
        #500000;
        $display("FAIL watchdog expired n_assert=%0d n_fail=%0d", n_assert, n_fail);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command from offer to response. gdelay: cycles bus_req waits for
    // grant; ack_wait: strobe cycles without ack before ack; err_mode: bus_err
    // on first strobe; drop_mode: grant withdrawn on first strobe; hold_next:
    // keep offering junk commands while busy.
    task automatic run_txn(input logic wr, input logic [22:0] a, input logic u,
                           input logic l, input logic [15:0] wd, input logic [15:0] rd,
                           input int gdelay, input int ack_wait, input logic err_mode,
                           input logic drop_mode, input logic hold_next);
        logic        nobus, exp_err, exp_to, granted, done;
        logic [15:0] exp_rdata, got_rdata;
        logic        got_err, got_to, got_req, got_as;
        int          exp_strobe, exp_lat, cyc, req_wait, grant_cyc, rsp_cyc;
        int          setup_n, strobe_n, release_n;

        nobus      = !u && !l;
        exp_to     = !nobus && !err_mode && !drop_mode && (ack_wait >= TIMEOUT);
        exp_err    = nobus || err_mode || drop_mode;
        exp_strobe = nobus ? 0 : ((err_mode || drop_mode) ? 1 :
                     ((ack_wait < TIMEOUT) ? ack_wait + 1 : TIMEOUT));
        exp_rdata  = (!nobus && !wr && !exp_err && !exp_to) ? rd : 16'h0000;
        exp_lat    = nobus ? 1 : SETUP + exp_strobe + 2;

        granted = 1'b0; done = 1'b0; cyc = 0; req_wait = 0; grant_cyc = 0; rsp_cyc = 0;
        setup_n = 0; strobe_n = 0; release_n = 0;
        got_rdata = 16'h0000; got_err = 1'b0; got_to = 1'b0; got_req = 1'b1; got_as = 1'b1;

        @(negedge clk30);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_no_rsp", 32'(rsp_valid), 32'd0);
        chk("hold_rdata", 32'(rsp_rdata), 32'(last_rdata));
        chk("hold_err", 32'(rsp_err), 32'(last_err));
        chk("hold_timeout", 32'(rsp_timeout), 32'(last_to));
        bus_grant = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
        cmd_uds = u; cmd_lds = l; cmd_wdata = wd;

        while (!done && cyc < 200) begin
            @(negedge clk30);
            cyc++;
            bus_ack = 1'b0; bus_err = 1'b0; data_in = 16'($urandom);
            cmd_valid = hold_next;
            if (hold_next) begin
                cmd_write = 1'($urandom); cmd_addr = 23'($urandom);
                cmd_uds = 1'($urandom); cmd_lds = 1'($urandom); cmd_wdata = 16'($urandom);
            end
            chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);

            // Arbiter model: grant after gdelay request cycles, drop with request.
            if (bus_req && !granted) begin
                if (req_wait == gdelay) begin
                    bus_grant = 1'b1; granted = 1'b1; grant_cyc = cyc;
                end else begin
                    req_wait++;
                end
            end
            if (!bus_req) bus_grant = 1'b0;

            if (as && !uds && !lds) begin
                setup_n++;
                chk("setup_addr", 32'(addr), 32'(a));
                chk("setup_wstrobe", 32'(write_strobe), 32'(wr));
            end
            if (uds || lds) begin
                strobe_n++;
                chk("strobe_as", 32'(as), 32'd1);
                chk("strobe_uds", 32'(uds), 32'(u));
                chk("strobe_lds", 32'(lds), 32'(l));
                chk("strobe_addr", 32'(addr), 32'(a));
                chk("strobe_wstrobe", 32'(write_strobe), 32'(wr));
                chk("strobe_data_out", 32'(data_out), 32'(wr ? wd : 16'h0000));
                // Responder model.
                if (drop_mode) begin
                    if (strobe_n == 1) bus_grant = 1'b0;
                end else if (err_mode) begin
                    bus_err = 1'b1; bus_ack = 1'b1; data_in = rd;
                end else if (strobe_n > ack_wait) begin
                    bus_ack = 1'b1;
                    if (!wr) data_in = rd;
                end
            end
            if (strobe_n > 0 && !as && !uds && !lds && !write_strobe && bus_req) release_n++;
            if (rsp_valid) begin
                done = 1'b1; rsp_cyc = cyc;
                got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
                got_req = bus_req; got_as = as;
            end
        end
        bus_ack = 1'b0; bus_err = 1'b0;

        chk("rsp_seen", 32'(done), 32'd1);
        chk("rsp_rdata", 32'(got_rdata), 32'(exp_rdata));
        chk("rsp_err", 32'(got_err), 32'(exp_err));
        chk("rsp_timeout", 32'(got_to), 32'(exp_to));
        chk("done_bus_req", 32'(got_req), 32'd0);
        chk("done_as", 32'(got_as), 32'd0);
        chk("setup_len", 32'(setup_n), 32'(nobus ? 0 : SETUP));
        chk("strobe_len", 32'(strobe_n), 32'(exp_strobe));
        chk("release_len", 32'(release_n), 32'(nobus ? 0 : 1));
        chk("latency", 32'(rsp_cyc - grant_cyc), 32'(exp_lat));
        last_rdata = exp_rdata; last_err = exp_err; last_to = exp_to;
    endtask

    initial begin
        logic [22:0] ra;
        logic        rw, ru, rl;
        int          mode;

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 23'h0;
        cmd_uds = 1'b0; cmd_lds = 1'b0; cmd_wdata = 16'h0; bus_grant = 1'b0;
        data_in = 16'h0; bus_ack = 1'b0; bus_err = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk30);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_as", 32'(as), 32'd0);
        chk("rst_uds", 32'(uds), 32'd0);
        chk("rst_lds", 32'(lds), 32'd0);
        chk("rst_wstrobe", 32'(write_strobe), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        reset = 1'b0;

        // Word write 0x1234 to byte 0x000100, immediate grant, zero-wait ack.
        run_txn(1'b1, 23'h000080, 1'b1, 1'b1, 16'h1234, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b0);
        // Read 0x300000, five wait states then 0xBEEF.
        run_txn(1'b0, 23'h180000, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0, 5, 1'b0, 1'b0, 1'b0);
        // Read 0x600000 with bus_err and bus_ack together.
        run_txn(1'b0, 23'h300000, 1'b1, 1'b1, 16'h0000, 16'hCAFE, 0, 0, 1'b1, 1'b0, 1'b0);
        // No ack ever: timeout after TIMEOUT strobe cycles.
        run_txn(1'b0, 23'h012345, 1'b1, 1'b1, 16'h0000, 16'h5A5A, 3, 100, 1'b0, 1'b0, 1'b0);
        // Grant withdrawn during strobe.
        run_txn(1'b0, 23'h054321, 1'b1, 1'b0, 16'h0000, 16'h7777, 1, 0, 1'b0, 1'b1, 1'b0);
        // No byte lanes enabled.
        run_txn(1'b1, 23'h0000AA, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b0);
        // Lower-byte write to 0x320002, then a back-to-back upper-byte read.
        run_txn(1'b1, 23'h190001, 1'b0, 1'b1, 16'h00AB, 16'h0000, 0, 2, 1'b0, 1'b0, 1'b1);
        run_txn(1'b0, 23'h190001, 1'b1, 1'b0, 16'h0000, 16'h9100, 2, 1, 1'b0, 1'b0, 1'b0);

        // Randomized commands.
        for (int i = 0; i < 24; i++) begin
            rw   = 1'($urandom);
            ra   = 23'($urandom);
            ru   = ($urandom_range(0, 5) != 0);
            rl   = ($urandom_range(0, 5) != 0);
            mode = $urandom_range(0, 7);
            run_txn(rw, ra, ru, rl, 16'($urandom), 16'($urandom), $urandom_range(0, 4),
                    (mode == 2) ? 100 : $urandom_range(0, 8),
                    (mode == 0), (mode == 1), 1'($urandom));
        end

        // Grant withheld 10 cycles, then reset while strobing.
        @(negedge clk30);
        bus_grant = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 23'h001000;
        cmd_uds = 1'b1; cmd_lds = 1'b1; cmd_wdata = 16'h0000;
        @(negedge clk30);
        cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("wait_bus_req", 32'(bus_req), 32'd1);
            chk("wait_no_as", 32'(as), 32'd0);
            @(negedge clk30);
        end
        bus_grant = 1'b1;
        for (int k = 0; k < 20 && !(uds || lds); k++) @(negedge clk30);
        chk("rst_reach_strobe", 32'(uds | lds), 32'd1);
        reset = 1'b1;
        @(negedge clk30);
        reset = 1'b0;
        bus_grant = 1'b0;
        chk("mid_rst_as", 32'(as), 32'd0);
        chk("mid_rst_uds", 32'(uds), 32'd0);
        chk("mid_rst_lds", 32'(lds), 32'd0);
        chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk30);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_idle_req", 32'(bus_req), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
